avl_wait_slave_mem: RTL and testbench
=====================================

Name: avl_wait_slave_mem

Overview:
- Avalon-MM memory slave with programmable wait-state insertion. It is the responder end of the CPU's Harvard-to-Avalon bus interface.
- Two word-addressed regions: an instruction block at 0xBFC00000 and a data block at 0x00000000, each initialised from a hex file.
- Holds waitrequest high for a configurable number of cycles, so master stall and handshake logic are exercised under non-zero latency.

Parameters:
- INSTR_INIT_FILE, "", $readmemh file for the instruction block; empty string means no init (zeros).
- DATA_INIT_FILE, "", $readmemh file for the data block; empty string means no init.
- BLOCK_SIZE, 8192, size of each region in bytes; power of two, multiple of 4.
- WAIT_CYCLES, 2, extra wait cycles inserted per transfer, range 0..15.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- address  input  32  byte address; bits [1:0] ignored.
- byteenable  input  4  write lane enables; bit i covers writedata[8i+7:8i].
- writedata  input  32  write data.
- read  input  1  read request.
- write  input  1  write request.
- readdata  output  32  registered read data.
- waitrequest  output  1  high = transfer not yet accepted.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, waitrequest=1, readdata=32'h0, wait counter=0.
  - Memory contents are not cleared.
  - A transfer in flight is aborted; no write is committed.
- Address decode on address[31:2]:
  - INSTR hit: address in [0xBFC00000, 0xBFC00000+BLOCK_SIZE).
  - DATA hit: address in [0, BLOCK_SIZE).
  - Anything else is unmapped: reads return 32'h0, writes are dropped, and the handshake still completes.
- FSM states: IDLE, WAIT, ACK. State is registered; waitrequest = (state != ACK).
  - IDLE: if read|write is sampled high, latch address, byteenable, writedata and op. Go to ACK if WAIT_CYCLES==0, else go to WAIT with cnt=WAIT_CYCLES-1.
  - WAIT: if cnt!=0, decrement and stay; if cnt==0, go to ACK.
  - On the edge entering ACK: readdata <= word at the latched address (for reads); byte-enabled lanes are written (for writes).
  - ACK: one cycle with waitrequest=0, then unconditionally return to IDLE. Requests seen during ACK are ignored.
  - A request held into the following IDLE cycle starts a new transfer.
- Latency: request first high in cycle c, waitrequest low in cycle c+1+WAIT_CYCLES. A back-to-back transfer costs WAIT_CYCLES+2 cycles.
- read and write asserted together: treated as a write; readdata keeps its previous value.
- Read data uses the latched address. Changes to address during WAIT have no effect.
- Writes with byteenable=0000 complete the handshake and modify nothing.
- readdata holds its value outside ACK and after write transfers.
- Region index = (address - base) >> 2, i.e. BLOCK_SIZE/4 words per region.

Optional Feature:
- Macro: AVL_RANDOM_WAIT_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; reset seed 16'hACE1) steps once per accepted request.
  - Effective wait = WAIT_CYCLES + lfsr[1:0] (0..3 extra cycles).
  - The sequence is deterministic after reset.
- Undefined: fixed WAIT_CYCLES latency; no LFSR logic is present.

Decomposition:
- Package avl_slave_pkg holds:
  - the state_t enum {IDLE, WAIT, ACK};
  - INSTR_BASE=32'hBFC00000 and DATA_BASE=32'h00000000;
  - the LFSR seed and tap constants.
- Sub-module avl_byte_ram, instantiated once per region:
  - parameters WORDS and INIT_FILE;
  - synchronous word read, per-byte write enables, optional $readmemh init.
- Top level contains the decode, the FSM and the counter.

Test Plan:
- Reset check: WAIT_CYCLES=2, read 0xBFC00000 after reset release.
  - Expect waitrequest=1 in cycles c and c+1 and waitrequest=0 only in cycle c+3.
  - Expect readdata equal to INSTR file word 0.
  - Before the read, readdata must be 0.
- Byte-lane write: write 0x00000000 to 0xAC with byteenable=1111, then write 0xDDCCBBAA with byteenable=0001, then read 0xAC.
  - Expect 0x000000AA.
  - Repeat with byteenable 0010, 0100, 1000 on 0xB0, 0xB4, 0xB8 and expect 0x0000BB00, 0x00CC0000, 0xDD000000.
- Unmapped address: write 0x12345678 to 0x40000000, then read it back.
  - Handshake completes with the same latency; readdata=0.
  - DATA word 0 is unchanged.
- Reset mid-operation: assert rst=0 during WAIT of a write of 0xFFFFFFFF to 0x10, then release.
  - Expect waitrequest=1 and readdata=0 immediately after reset.
  - A later read of 0x10 returns the pre-write value.
- Simultaneous read and write to 0x20 with 0xCAFEF00D: write is committed and readdata is unchanged; a later read of 0x20 returns 0xCAFEF00D.
- Random waits (AVL_RANDOM_WAIT_EN defined): 100 back-to-back reads of 0x00..0x18C.
  - Every waitrequest-low pulse lasts exactly 1 cycle.
  - Wait counts lie in WAIT_CYCLES..WAIT_CYCLES+3.
  - All data matches the DATA file contents.

Source files
------------

// File: rtl/avl_slave_pkg.sv
// Shared types and constants for the wait-state Avalon-MM memory slave.
package avl_slave_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  // Source that currently drives readdata.
  typedef enum logic [1:0] {SEL_NONE, SEL_INSTR, SEL_DATA} rsel_t;

  localparam logic [31:0] INSTR_BASE = 32'hBFC0_0000;
  localparam logic [31:0] DATA_BASE  = 32'h0000_0000;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], ^(l & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/avl_byte_ram.sv
// Word-wide RAM with per-byte write enables and enabled synchronous read.
module avl_byte_ram #(
  parameter int unsigned WORDS     = 2048,
  parameter string       INIT_FILE = ""
) (
  input  logic                     clk,
  input  logic [$clog2(WORDS)-1:0] i_addr,
  input  logic                     i_rd_en,
  input  logic [3:0]               i_we,
  input  logic [31:0]              i_wdata,
  output logic [31:0]              o_rdata
);

  logic [31:0] r_mem [WORDS];
  logic [31:0] r_rdata;

  always_ff @(posedge clk) begin
    for (int unsigned b = 0; b < 4; b++) begin
      if (i_we[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
    end
    if (i_rd_en) r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/avl_wait_slave_mem.sv
// Avalon-MM memory slave (instruction + data regions) with wait-state insertion.
// Define AVL_RANDOM_WAIT_EN to add 0..3 LFSR-driven extra wait cycles.
module avl_wait_slave_mem
  import avl_slave_pkg::*;
#(
  parameter string       INSTR_INIT_FILE = "",
  parameter string       DATA_INIT_FILE  = "",
  parameter int unsigned BLOCK_SIZE      = 8192,
  parameter int unsigned WAIT_CYCLES     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address,
  input  logic [3:0]  byteenable,
  input  logic [31:0] writedata,
  input  logic        read,
  input  logic        write,
  output logic [31:0] readdata,
  output logic        waitrequest
);

  localparam int unsigned WORDS = BLOCK_SIZE / 4;
  localparam int unsigned AW    = $clog2(WORDS);

  state_t      r_state;
  logic [4:0]  r_cnt;
  logic [31:0] r_addr, r_wdata;
  logic [3:0]  r_be;
  logic        r_wr;
  logic        r_wait;
  rsel_t       r_rsel;

  logic        w_req, w_wr, w_fire, w_ihit, w_dhit;
  logic [31:0] w_addr, w_wdata, w_irdata, w_drdata;
  logic [3:0]  w_be;
  logic [29:0] w_iword, w_dword;
  logic [4:0]  w_eff_wait;

`ifdef AVL_RANDOM_WAIT_EN
  logic [15:0] r_lfsr;
  assign w_eff_wait = 5'(WAIT_CYCLES) + {3'b000, r_lfsr[1:0]};
`else
  assign w_eff_wait = 5'(WAIT_CYCLES);
`endif

  assign w_req = read | write;

  // In IDLE the live bus is used so a zero-wait transfer can commit on the
  // accepting edge; afterwards only the latched request matters.
  assign w_addr  = (r_state == IDLE) ? address    : r_addr;
  assign w_be    = (r_state == IDLE) ? byteenable : r_be;
  assign w_wdata = (r_state == IDLE) ? writedata  : r_wdata;
  assign w_wr    = (r_state == IDLE) ? write      : r_wr;

  assign w_fire = ((r_state == IDLE) && w_req && (w_eff_wait == 5'd0)) ||
                  ((r_state == WAIT) && (r_cnt == 5'd0));

  assign w_iword = w_addr[31:2] - INSTR_BASE[31:2];
  assign w_dword = w_addr[31:2] - DATA_BASE[31:2];
  assign w_ihit  = ({w_iword, w_addr[1:0]} < 32'(BLOCK_SIZE));
  assign w_dhit  = ({w_dword, w_addr[1:0]} < 32'(BLOCK_SIZE));

  avl_byte_ram #(.WORDS(WORDS), .INIT_FILE(INSTR_INIT_FILE)) u_instr (
    .clk     (clk),
    .i_addr  (w_iword[AW-1:0]),
    .i_rd_en (w_fire && !w_wr && w_ihit),
    .i_we    ((w_fire && w_wr && w_ihit) ? w_be : 4'b0000),
    .i_wdata (w_wdata),
    .o_rdata (w_irdata)
  );

  avl_byte_ram #(.WORDS(WORDS), .INIT_FILE(DATA_INIT_FILE)) u_data (
    .clk     (clk),
    .i_addr  (w_dword[AW-1:0]),
    .i_rd_en (w_fire && !w_wr && w_dhit),
    .i_we    ((w_fire && w_wr && w_dhit) ? w_be : 4'b0000),
    .i_wdata (w_wdata),
    .o_rdata (w_drdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_wr    <= 1'b0;
      r_wait  <= 1'b1;
      r_rsel  <= SEL_NONE;
`ifdef AVL_RANDOM_WAIT_EN
      r_lfsr  <= LFSR_SEED;
`endif
    end else begin
      r_wait <= !w_fire;
      if (w_fire && !w_wr) begin
        r_rsel <= w_ihit ? SEL_INSTR : (w_dhit ? SEL_DATA : SEL_NONE);
      end
      unique case (r_state)
        IDLE: begin
          if (w_req) begin
            r_addr  <= address;
            r_wdata <= writedata;
            r_be    <= byteenable;
            r_wr    <= write;
`ifdef AVL_RANDOM_WAIT_EN
            r_lfsr  <= lfsr_next(r_lfsr);
`endif
            if (w_eff_wait == 5'd0) begin
              r_state <= ACK;
            end else begin
              r_state <= WAIT;
              r_cnt   <= w_eff_wait - 5'd1;
            end
          end
        end
        WAIT: begin
          if (r_cnt != 5'd0) r_cnt   <= r_cnt - 5'd1;
          else               r_state <= ACK;
        end
        ACK:     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    readdata = '0;
    unique case (r_rsel)
      SEL_INSTR: readdata = w_irdata;
      SEL_DATA:  readdata = w_drdata;
      default:   readdata = '0;
    endcase
  end

  assign waitrequest = r_wait;

endmodule

// File: tb/tb_avl_wait_slave_mem.sv
// Directed self-checking bench for avl_wait_slave_mem (WAIT_CYCLES=2, no init files).
module tb_avl_wait_slave_mem;

  localparam int W = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] address = '0;
  logic [3:0]  byteenable = '0;
  logic [31:0] writedata = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] readdata;
  logic        waitrequest;

  int n_chk = 0;
  int n_err = 0;

  avl_wait_slave_mem #(
    .INSTR_INIT_FILE (""),
    .DATA_INIT_FILE  (""),
    .BLOCK_SIZE      (8192),
    .WAIT_CYCLES     (W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .address     (address),
    .byteenable  (byteenable),
    .writedata   (writedata),
    .read        (read),
    .write       (write),
    .readdata    (readdata),
    .waitrequest (waitrequest)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic check_lat(input string tag, input int lat);
`ifdef AVL_RANDOM_WAIT_EN
    check(tag, 32'(lat >= W + 1 && lat <= W + 4), 32'd1);
`else
    check(tag, 32'(lat), 32'(W + 1));
`endif
  endtask

  function automatic logic [31:0] pat(input int i);
    return 32'h5A5A_0000 + 32'(i) * 32'h0001_0101;
  endfunction

  // One full handshake; lat counts sampled cycles from the request edge to
  // the cycle with waitrequest low.
  task automatic xfer(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd,
                      input logic rd, input logic wr,
                      output logic [31:0] rdat, output int lat);
    @(negedge clk);
    address = a; byteenable = be; writedata = wd; read = rd; write = wr;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (waitrequest && lat < 40);
    check("handshake", {31'b0, waitrequest}, 32'd0);
    rdat = readdata;
    read = 1'b0; write = 1'b0;
    @(negedge clk);
    check("ack_one_cycle", {31'b0, waitrequest}, 32'd1);
  endtask

  task automatic wr32(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
    logic [31:0] d;
    int l;
    xfer(a, be, wd, 1'b0, 1'b1, d, l);
    check_lat("write_latency", l);
  endtask

  task automatic rd32(input logic [31:0] a, output logic [31:0] d);
    int l;
    xfer(a, 4'b0000, 32'h0, 1'b1, 1'b0, d, l);
    check_lat("read_latency", l);
  endtask

  logic [31:0] d;
  int          lat;
  logic [31:0] lane_addr [4] = '{32'hAC, 32'hB0, 32'hB4, 32'hB8};
  logic [3:0]  lane_be   [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
  logic [31:0] lane_exp  [4] = '{32'h0000_00AA, 32'h0000_BB00, 32'h00CC_0000, 32'hDD00_0000};

  initial begin
    repeat (3) @(negedge clk);
    check("reset_waitrequest", {31'b0, waitrequest}, 32'd1);
    check("reset_readdata", readdata, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    check("readdata_before_read", readdata, 32'h0);

    xfer(32'hBFC0_0000, 4'b0000, 32'h0, 1'b1, 1'b0, d, lat);
    check_lat("instr0_latency", lat);
    check("instr0_zero_init", d, 32'h0);

    wr32(32'hBFC0_0000, 4'b1111, 32'h3C08_BFC0);
    rd32(32'hBFC0_0004, d);
    check("instr1_untouched", d, 32'h0);
    rd32(32'hBFC0_0000, d);
    check("instr0_readback", d, 32'h3C08_BFC0);
    rd32(32'hBFC0_2000, d);
    check("instr_past_end", d, 32'h0);

    for (int i = 0; i < 100; i++) wr32(32'(i * 4), 4'b1111, pat(i));
    for (int i = 0; i < 100; i++) begin
      rd32(32'(i * 4), d);
      check("data_fill", d, pat(i));
    end

    wr32(32'h0000_1FFC, 4'b1111, 32'h1234_ABCD);
    wr32(32'h0000_2000, 4'b1111, 32'hDEAD_BEEF);
    rd32(32'h0000_1FFC, d);
    check("data_last_word", d, 32'h1234_ABCD);
    rd32(32'h0000_0000, d);
    check("data_no_alias", d, pat(0));

    for (int k = 0; k < 4; k++) begin
      wr32(lane_addr[k], 4'b1111, 32'h0000_0000);
      wr32(lane_addr[k], lane_be[k], 32'hDDCC_BBAA);
      rd32(lane_addr[k], d);
      check("byte_lane", d, lane_exp[k]);
    end

    wr32(32'hAC, 4'b0000, 32'h1111_1111);
    check("readdata_hold_after_write", readdata, 32'hDD00_0000);
    rd32(32'hAC, d);
    check("be_none", d, 32'h0000_00AA);

    xfer(32'h4000_0000, 4'b1111, 32'h1234_5678, 1'b0, 1'b1, d, lat);
    check_lat("unmapped_wr_latency", lat);
    check("unmapped_wr_hold", d, 32'h0000_00AA);
    xfer(32'h4000_0000, 4'b0000, 32'h0, 1'b1, 1'b0, d, lat);
    check_lat("unmapped_rd_latency", lat);
    check("unmapped_rd", d, 32'h0);
    rd32(32'h0, d);
    check("unmapped_data0", d, pat(0));

    @(negedge clk);
    address = 32'h10; byteenable = 4'b1111; writedata = 32'hFFFF_FFFF; write = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midop_waitrequest", {31'b0, waitrequest}, 32'd1);
    check("midop_readdata", readdata, 32'h0);
    write = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    rd32(32'h10, d);
    check("midop_not_committed", d, pat(4));

    xfer(32'h20, 4'b1111, 32'hCAFE_F00D, 1'b1, 1'b1, d, lat);
    check_lat("rdwr_latency", lat);
    check("rdwr_readdata_kept", d, pat(4));
    rd32(32'h20, d);
    check("rdwr_committed", d, 32'hCAFE_F00D);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
